oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter M_CYCLE_CLKS, default 4, clocks per byte slot; legal range 3..15.
REQ-002 Parameter OAM_BYTES, default 160, bytes per transfer.
REQ-003 clk  in  1  system clock (4 MHz); single clock domain.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 reg_enable  in  1  FF46 register access strobe, already decoded.
REQ-006 reg_write  in  1  1 = write, 0 = read.
REQ-007 reg_data_in  in  8  FF46 write data (source page).
REQ-008 reg_data_out  out  8  FF46 read data.
REQ-009 bus_req  out  1  read request to system bus arbiter.
REQ-010 bus_addr  out  16  read address, valid while bus_req=1.
REQ-011 bus_gnt  in  1  grant; read accepted in any cycle where bus_req=1 and bus_gnt=1.
REQ-012 bus_rdata  in  8  read data, valid exactly one cycle after the accepting cycle.
REQ-013 oam_addr  out  8  OAM byte index.
REQ-014 oam_write  out  1  OAM write strobe.
REQ-015 oam_wdata  out  8  OAM write data.
REQ-016 dma_active  out  1  high from start to end of transfer; CPU OAM/bus access blocked while high.

Function
REQ-017 States: IDLE, DELAY, REQ, WR, PAD.
REQ-018 A reg write of value S in any state SHALL store S, clear the byte index to 0 and enter DELAY next cycle.
REQ-019 A reg read SHALL return the last written S on reg_data_out in the following cycle; reg_data_out holds otherwise.
REQ-020 Effective source page P = S-0x20 when S >= 0xE0, else P = S; bus_addr = {P, index}.
REQ-021 DELAY: dma_active=1, no bus or OAM activity for exactly M_CYCLE_CLKS cycles, then REQ.
REQ-022 REQ: bus_req=1; remain until bus_gnt=1 (unbounded stall allowed), then WR.
REQ-023 WR (one cycle): oam_write=1, oam_addr=index, oam_wdata=bus_rdata (combinational pass-through).
REQ-024 PAD: idle until M_CYCLE_CLKS cycles have elapsed since the cycle bus_req was granted minus one (i.e. REQ-grant cycle + WR + PAD = M_CYCLE_CLKS with zero stall).
REQ-025 End of PAD: if index = OAM_BYTES-1, go to IDLE and deassert dma_active; else increment index and go to REQ.
REQ-026 Zero-stall transfer: OAM_BYTES*M_CYCLE_CLKS cycles after DELAY (640 clocks at defaults).
REQ-027 A restart write arriving in WR: that cycle's OAM write still completes; next state is DELAY, index 0.
REQ-028 A restart write in REQ: bus_req drops next cycle; any grant in the write cycle is discarded.
REQ-029 bus_req, oam_write = 0 in IDLE, DELAY and PAD; index is 8 bits and never exceeds OAM_BYTES-1.
REQ-030 Simultaneous reg read and active transfer: both proceed with no interaction.

Reset
REQ-031 While reset_n=0: state IDLE, index 0, S=0xFF, reg_data_out=0xFF, bus_req=0, bus_addr=0, oam_write=0, oam_addr=0, dma_active=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no further OAM writes; no resumption after release.

Structure
REQ-033 Shared package ppu_pkg SHALL hold the dma state enum, OAM_BYTES, DMA_REG_ADDR (7'h46) and ECHO_PAGE_BASE (8'hE0).
REQ-034 Implemented as one module; no sub-module. Slot counter and index counter are local registers.

Verification
REQ-035 Write 0xC0, bus_gnt tied 1, bus_rdata = low address byte -> after 4-cycle DELAY, OAM[i]=i for i=0..159, dma_active high for 644 cycles total.
REQ-036 Write 0xE3 -> bus_addr sequence 0xC300..0xC39F.
REQ-037 bus_gnt held 0 for 10 cycles at byte 5 -> bus_req stays high with bus_addr 0xC005, no OAM write; byte 5 slot stretches to 14 cycles; data still correct.
REQ-038 Write 0xC0, then write 0xD0 during WR of byte 20 -> byte 20 written, then DELAY, then OAM[0..159] overwritten from 0xD000.
REQ-039 reset_n pulsed low during byte 50 -> all outputs at reset values asynchronously, OAM[50..159] untouched, FF46 reads 0xFF.
REQ-040 Write 0x42 then read FF46 -> reg_data_out = 0x42 one cycle after the read strobe.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding, register address and source-page helpers.
package ppu_pkg;

  typedef enum logic [2:0] {
    DmaIdle,
    DmaDelay,
    DmaReq,
    DmaWr,
    DmaPad
  } dma_state_e;

  localparam int unsigned OAM_BYTES      = 160;
  localparam logic [6:0]  DMA_REG_ADDR   = 7'h46;
  localparam logic [7:0]  ECHO_PAGE_BASE = 8'hE0;

  // Pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] dma_src_page(input logic [7:0] s);
    return (s >= ECHO_PAGE_BASE) ? (s - 8'h20) : s;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_BYTES bytes from page {P,00} into OAM, one byte per slot of
// M_CYCLE_CLKS clocks, after a one-slot start-up delay.
module oam_dma #(
  parameter int unsigned M_CYCLE_CLKS = 4,
  parameter int unsigned OAM_BYTES    = ppu_pkg::OAM_BYTES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_enable,
  input  logic        reg_write,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  input  logic        bus_gnt,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);
  import ppu_pkg::*;

  localparam logic [3:0] DelayLast = 4'(M_CYCLE_CLKS - 1);
  // The grant cycle and the WR cycle already consume two clocks of the slot.
  localparam logic [3:0] PadLast   = 4'(M_CYCLE_CLKS - 3);
  localparam logic [7:0] IdxLast   = 8'(OAM_BYTES - 1);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] src_q, src_d;
  logic [7:0] rdout_q, rdout_d;

  logic wr_stb;
  logic rd_stb;

  assign wr_stb = reg_enable & reg_write;
  assign rd_stb = reg_enable & ~reg_write;

  // State, counters and FF46 registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DmaIdle;
      idx_q   <= 8'h00;
      cnt_q   <= 4'h0;
      src_q   <= 8'hFF;
      rdout_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rdout_q <= rdout_d;
    end
  end

  // Next-state and transfer outputs; a register write restarts from any state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bus_req    = 1'b0;
    oam_write  = 1'b0;
    oam_wdata  = 8'h00;
    dma_active = 1'b0;

    unique case (state_q)
      DmaIdle: begin
      end
      DmaDelay: begin
        dma_active = 1'b1;
        if (cnt_q == DelayLast) begin
          state_d = DmaReq;
          cnt_d   = 4'h0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DmaReq: begin
        dma_active = 1'b1;
        bus_req    = 1'b1;
        if (bus_gnt) begin
          state_d = DmaWr;
        end
      end
      DmaWr: begin
        dma_active = 1'b1;
        oam_write  = 1'b1;
        oam_wdata  = bus_rdata;
        state_d    = DmaPad;
        cnt_d      = 4'h0;
      end
      DmaPad: begin
        dma_active = 1'b1;
        if (cnt_q == PadLast) begin
          cnt_d = 4'h0;
          if (idx_q == IdxLast) begin
            state_d = DmaIdle;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = DmaReq;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = DmaIdle;
      end
    endcase

    // Restart overrides the transition; an in-flight WR still writes this cycle.
    if (wr_stb) begin
      state_d = DmaDelay;
      idx_d   = 8'h00;
      cnt_d   = 4'h0;
    end
  end

  // FF46 write captures the page; a read latches it onto reg_data_out.
  always_comb begin
    src_d   = wr_stb ? reg_data_in : src_q;
    rdout_d = rd_stb ? src_q : rdout_q;
  end

  assign reg_data_out = rdout_q;
  assign bus_addr     = bus_req ? {dma_src_page(src_q), idx_q} : 16'h0000;
  assign oam_addr     = idx_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a bus memory model plus an OAM-write scoreboard.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_enable = 1'b0;
  logic        reg_write = 1'b0;
  logic [7:0]  reg_data_in = 8'h00;
  logic [7:0]  reg_data_out;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_gnt = 1'b1;
  logic [7:0]  bus_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc [256];
  logic [15:0] exp_q [$];
  logic [15:0] acc_q [$];

  oam_dma #(.M_CYCLE_CLKS(4), .OAM_BYTES(160)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .reg_enable   (reg_enable),
    .reg_write    (reg_write),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_gnt      (bus_gnt),
    .bus_rdata    (bus_rdata),
    .oam_addr     (oam_addr),
    .oam_write    (oam_write),
    .oam_wdata    (oam_wdata),
    .dma_active   (dma_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hash(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Memory model: data returned the cycle after an accepted read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_req && bus_gnt) begin
      bus_rdata <= hash(bus_addr);
      acc_q.push_back(bus_addr);
    end
  end

  // Scoreboard: every OAM write must match the next expected {index, data}.
  always @(negedge clk) begin
    if (oam_write) begin
      logic [15:0] e;
      checks++;
      wr_cyc[oam_addr] = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL oam_write_unexpected addr=%02h data=%02h", oam_addr, oam_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({oam_addr, oam_wdata} !== e) begin
          errors++;
          $display("FAIL oam_write got addr=%02h data=%02h want addr=%02h data=%02h",
                   oam_addr, oam_wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_xfer(input logic [7:0] s, input int n);
    logic [7:0] p;
    p = (s >= 8'hE0) ? (s - 8'h20) : s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), hash({p, 8'(i)})});
    end
  endtask

  // Called at a negedge; returns at the negedge of the first DELAY cycle.
  task automatic do_write(input logic [7:0] d);
    reg_enable  = 1'b1;
    reg_write   = 1'b1;
    reg_data_in = d;
    @(negedge clk);
    reg_enable = 1'b0;
    reg_write  = 1'b0;
  endtask

  task automatic wait_idle(output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (dma_active) begin
      n++;
      if (n > 3000) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (reg_data_out !== 8'hFF) begin
      errors++; $display("FAIL reset_rdout got %02h want ff", reg_data_out);
    end
    checks++;
    if ({bus_req, oam_write, dma_active} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b wr=%b act=%b want 000", bus_req, oam_write, dma_active);
    end
    checks++;
    if (bus_addr !== 16'h0000 || oam_addr !== 8'h00) begin
      errors++; $display("FAIL reset_addr got bus=%04h oam=%02h want 0000/00", bus_addr, oam_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dma_active !== 1'b0 || reg_data_out !== 8'hFF) begin
      errors++; $display("FAIL post_reset got act=%b rd=%02h want 0/ff", dma_active, reg_data_out);
    end
  endtask

  task automatic test_reg_read;
    int n; bit to;
    push_xfer(8'h42, 160);
    do_write(8'h42);
    checks++;
    if (reg_data_out !== 8'hFF) begin
      errors++; $display("FAIL rdout_hold got %02h want ff", reg_data_out);
    end
    reg_enable = 1'b1;
    reg_write  = 1'b0;
    @(negedge clk);
    reg_enable = 1'b0;
    checks++;
    if (reg_data_out !== 8'h42 || dma_active !== 1'b1) begin
      errors++; $display("FAIL reg_read got rd=%02h act=%b want 42/1", reg_data_out, dma_active);
    end
    wait_idle(n, to);
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++; $display("FAIL read_xfer got timeout=%0d left=%0d want 0/0", to, exp_q.size());
    end
  endtask

  task automatic test_full;
    int n; int m; bit to; bit bad;
    push_xfer(8'hC0, 160);
    do_write(8'hC0);
    n = 0; bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus_req !== 1'b0 || oam_write !== 1'b0 || dma_active !== 1'b1) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL delay_quiet got activity=1 want 0");
    end
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 16'hC000) begin
      errors++; $display("FAIL first_req got req=%b addr=%04h want 1/c000", bus_req, bus_addr);
    end
    wait_idle(m, to);
    checks++;
    if (to || n + m != 644) begin
      errors++; $display("FAIL active_len got %0d (to=%0d) want 644", n + m, to);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL full_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_echo;
    int n; bit to; int bad_i;
    acc_q.delete();
    push_xfer(8'hE3, 160);
    do_write(8'hE3);
    wait_idle(n, to);
    bad_i = -1;
    for (int i = 0; i < 160 && i < acc_q.size(); i++) begin
      if (bad_i < 0 && acc_q[i] !== (16'hC300 + 16'(i))) bad_i = i;
    end
    checks++;
    if (to || acc_q.size() != 160 || bad_i >= 0) begin
      errors++;
      $display("FAIL echo_addr got count=%0d first_bad=%0d want 160/-1", acc_q.size(), bad_i);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL echo_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_stall;
    int n; bit to; bit bad; bit found;
    push_xfer(8'hC0, 160);
    do_write(8'hC0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus_req && bus_addr == 16'hC005) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL stall_find got none want req at c005");
    end
    bus_gnt = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus_req !== 1'b1 || bus_addr !== 16'hC005 || oam_write !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    bus_gnt = 1'b1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL stall_hold got dropped=1 want req held at c005");
    end
    wait_idle(n, to);
    checks++;
    if (wr_cyc[5] - wr_cyc[4] != 14 || wr_cyc[6] - wr_cyc[5] != 4) begin
      errors++;
      $display("FAIL stall_slot got %0d/%0d want 14/4", wr_cyc[5] - wr_cyc[4], wr_cyc[6] - wr_cyc[5]);
    end
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_left got timeout=%0d left=%0d want 0/0", to, exp_q.size());
    end
  endtask

  task automatic test_restart;
    int n; bit to; bit bad; bit found;
    push_xfer(8'hC0, 21);
    do_write(8'hC0);
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (oam_write && oam_addr == 8'd20) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL restart_find got none want WR of byte 20");
    end
    push_xfer(8'hD0, 160);
    do_write(8'hD0);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus_req !== 1'b0 || oam_write !== 1'b0 || dma_active !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL restart_delay got activity=1 want 0");
    end
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 16'hD000) begin
      errors++; $display("FAIL restart_req got req=%b addr=%04h want 1/d000", bus_req, bus_addr);
    end
    wait_idle(n, to);
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++; $display("FAIL restart_left got timeout=%0d left=%0d want 0/0", to, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit bad; bit found;
    push_xfer(8'hC0, 50);
    do_write(8'hC0);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus_req && bus_addr == 16'hC032) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_find got none want req at c032");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, oam_write, dma_active} !== 3'b000 || bus_addr !== 16'h0000 ||
        oam_addr !== 8'h00 || reg_data_out !== 8'hFF) begin
      errors++;
      $display("FAIL rstmid_async got req=%b wr=%b act=%b bus=%04h oam=%02h rd=%02h want reset values",
               bus_req, oam_write, dma_active, bus_addr, oam_addr, reg_data_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (dma_active !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || exp_q.size() != 0) begin
      errors++; $display("FAIL rstmid_resume got act=%b left=%0d want 0/0", bad, exp_q.size());
    end
    reg_enable = 1'b1;
    reg_write  = 1'b0;
    @(negedge clk);
    reg_enable = 1'b0;
    checks++;
    if (reg_data_out !== 8'hFF) begin
      errors++; $display("FAIL rstmid_read got %02h want ff", reg_data_out);
    end
  endtask

  initial begin
    test_reset();
    test_reg_read();
    test_full();
    test_echo();
    test_stall();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
